// File: rtl/phy_pkg.sv
// Shared definitions for the receive path: symbol width, FIFO entry layout
// and the byte-packing helper used by the symbol deframer.
package phy_pkg;

    localparam int SYM_W              = 2;
    localparam int DEF_SYMS_PER_FRAME = 63;

    typedef struct packed {
        logic       tuser;
        logic       tlast;
        logic [7:0] tdata;
    } fifo_entry_t;

    // Insert a dibit into its MSB-first lane; lane 0 starts a fresh byte so
    // stale bits from the previous byte never leak into the low positions.
    function automatic logic [7:0] place_sym(input logic [7:0]       cur,
                                             input logic [1:0]       lane,
                                             input logic [SYM_W-1:0] sym);
        logic [7:0] b;
        b = (lane == 2'd0) ? 8'h00 : cur;
        case (lane)
            2'd0:    b[7:6] = sym;
            2'd1:    b[5:4] = sym;
            2'd2:    b[3:2] = sym;
            default: b[1:0] = sym;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is fine when the head leaves on the same edge.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; only the control state is reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/symbol_deframer.sv
// Packs QPSK dibits MSB-first into bytes, closes frames on symbol count or
// on an idle-gap timeout, and streams the bytes out through a FWFT FIFO as
// an AXI4-Stream master. The input cannot be stalled, so a full FIFO drops.
module symbol_deframer
    import phy_pkg::*;
#(
    parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME,
    parameter int GAP_TIMEOUT    = 64,
    parameter int FIFO_DEPTH     = 32,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             clr_status,
    output logic             overflow,
    output logic [CNT_W-1:0] frames_done,
    output logic [CNT_W-1:0] bytes_dropped
);

    localparam int SCW = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1;
    localparam int GW  = $clog2(GAP_TIMEOUT + 1);
    localparam logic [SCW-1:0] LAST_SYM = SCW'(SYMS_PER_FRAME - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_TIMEOUT - 1);

    // Packing state. sym_cnt_q == 0 is the idle condition; non-zero means a
    // frame is open. The timeout close is a single-edge action, not a state.
    logic [SCW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [1:0]       lane_q, lane_d;
    logic [7:0]       shift_q, shift_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

    logic             overflow_q;
    logic [CNT_W-1:0] frames_done_q, bytes_dropped_q;

    logic             wr_req, frame_done, pop, drop;
    logic [7:0]       cur_byte;
    fifo_entry_t      wr_entry, rd_entry;
    logic             fifo_full, fifo_empty;

    // Next-state for packing, frame closing and the gap timeout.
    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        lane_d     = lane_q;
        shift_d    = shift_q;
        gap_cnt_d  = gap_cnt_q;
        wr_req     = 1'b0;
        wr_entry   = '0;
        frame_done = 1'b0;
        cur_byte   = place_sym(shift_q, lane_q, in_data);

        if (in_valid) begin
            // A symbol always wins over a timeout landing on the same edge.
            gap_cnt_d = '0;
            shift_d   = cur_byte;
            if (lane_q == 2'd3 || sym_cnt_q == LAST_SYM) begin
                wr_req         = 1'b1;
                wr_entry.tdata = cur_byte;
                lane_d         = 2'd0;
                if (sym_cnt_q == LAST_SYM) begin
                    wr_entry.tlast = 1'b1;
                    sym_cnt_d      = '0;
                    frame_done     = 1'b1;
                end else begin
                    sym_cnt_d = sym_cnt_q + SCW'(1);
                end
            end else begin
                lane_d    = lane_q + 2'd1;
                sym_cnt_d = sym_cnt_q + SCW'(1);
            end
        end else if (sym_cnt_q != '0) begin
            if (gap_cnt_q == GAP_LAST) begin
                // Force-close the truncated frame with whatever is packed.
                wr_req         = 1'b1;
                wr_entry.tdata = (lane_q == 2'd0) ? 8'h00 : shift_q;
                wr_entry.tlast = 1'b1;
                wr_entry.tuser = 1'b1;
                sym_cnt_d      = '0;
                lane_d         = 2'd0;
                gap_cnt_d      = '0;
            end else begin
                gap_cnt_d = gap_cnt_q + GW'(1);
            end
        end else begin
            gap_cnt_d = '0;
        end
    end

    // Packing state registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sym_cnt_q <= '0;
            lane_q    <= 2'd0;
            shift_q   <= 8'h00;
            gap_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            lane_q    <= lane_d;
            shift_q   <= shift_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign drop = wr_req && fifo_full && !pop;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Status: sticky overflow, wrapping frame count, saturating drop count;
    // a clear takes priority over any event on the same edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q      <= 1'b0;
            frames_done_q   <= '0;
            bytes_dropped_q <= '0;
        end else if (clr_status) begin
            overflow_q      <= 1'b0;
            frames_done_q   <= '0;
            bytes_dropped_q <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (bytes_dropped_q != '1) bytes_dropped_q <= bytes_dropped_q + CNT_W'(1);
            end
            if (frame_done) frames_done_q <= frames_done_q + CNT_W'(1);
        end
    end

    // Outputs read zero whenever nothing is presented.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 8'h00 : rd_entry.tdata;
    assign m_axis_tlast  = fifo_empty ? 1'b0  : rd_entry.tlast;
    assign m_axis_tuser  = fifo_empty ? 1'b0  : rd_entry.tuser;
    assign overflow      = overflow_q;
    assign frames_done   = frames_done_q;
    assign bytes_dropped = bytes_dropped_q;

endmodule
